// File: rtl/tpr_pkg.sv
// Shared types and constants for the toggle req/ack memory-port responder.
package tpr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2
    } tpr_state_t;

    localparam int unsigned SYNC_NONE = 0;
    localparam int unsigned SYNC_CDC  = 2;

    // Read-timeout counter width; kept at least one bit so TIMEOUT=0 still elaborates.
    function automatic int unsigned tpr_cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/tpr_sync.sv
// Multi-stage bit synchroniser for the request toggle; wire-through when STAGES is zero.
module tpr_sync
    import tpr_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_NONE
) (
    input  logic clk,
    input  logic i_d,
    output logic o_q
);

    generate
        if (STAGES == 0) begin : g_bypass
            logic w_unused_clk;
            assign w_unused_clk = clk;
            assign o_q          = i_d;
        end else begin : g_sync
            logic [STAGES-1:0] r_sync;
            always_ff @(posedge clk) begin
                r_sync[0] <= i_d;
                for (int unsigned k = 1; k < STAGES; k++) begin
                    r_sync[k] <= r_sync[k-1];
                end
            end
            assign o_q = r_sync[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/toggle_port_responder.sv
// Responder end of the toggle req/ack port: one word access on a ready/valid memory
// bus per request toggle, with read timeout and overrun detection.
module toggle_port_responder
    import tpr_pkg::*;
#(
    parameter int unsigned AW      = 23,
    parameter int unsigned DW      = 16,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned SYNC    = SYNC_NONE
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            port_req,
    output logic            port_ack,
    input  logic [AW-1:0]   port_a,
    input  logic [DW/8-1:0] port_ds,
    input  logic            port_we,
    input  logic [DW-1:0]   port_d,
    output logic [DW-1:0]   port_q,
    output logic            mem_cmd_valid,
    input  logic            mem_cmd_ready,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_rvalid,
    output logic            busy,
    output logic            err_overrun,
    output logic            err_timeout
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned CW = tpr_cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    logic            w_req_s;
    tpr_state_t      r_state;
    logic            r_req_d;
    logic            r_ack;
    logic [DW-1:0]   r_q;
    logic            r_valid;
    logic [AW-1:0]   r_addr;
    logic            r_we;
    logic [BW-1:0]   r_be;
    logic [DW-1:0]   r_wdata;
    logic            r_err_ovr;
    logic            r_err_to;
    logic [CW-1:0]   r_cnt;

    tpr_sync #(.STAGES(SYNC)) u_req_sync (
        .clk (clk),
        .i_d (port_req),
        .o_q (w_req_s)
    );

    always_ff @(posedge clk) begin
        r_req_d <= w_req_s;
        if (reset) begin
            r_state   <= ST_IDLE;
            r_ack     <= w_req_s;
            r_q       <= '0;
            r_valid   <= 1'b0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_err_ovr <= 1'b0;
            r_err_to  <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (r_state != ST_IDLE && w_req_s != r_req_d) begin
                r_err_ovr <= 1'b1;
            end
            // Completion copies the synced req into ack: equals a flip normally, and
            // absorbs any toggles that arrived while busy so no extra access follows.
            case (r_state)
                ST_IDLE: begin
                    if (w_req_s != r_ack) begin
                        r_addr  <= port_a;
                        r_be    <= port_ds;
                        r_we    <= port_we;
                        r_wdata <= port_d;
                        r_valid <= 1'b1;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_cmd_ready) begin
                        r_valid <= 1'b0;
                        r_cnt   <= '0;
                        if (r_we) begin
                            r_ack   <= w_req_s;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_WAIT_RD;
                        end
                    end
                end
                ST_WAIT_RD: begin
                    if (mem_rvalid) begin
                        r_q     <= mem_rdata;
                        r_ack   <= w_req_s;
                        r_state <= ST_IDLE;
                    end else if (TIMEOUT != 0 && r_cnt == CNT_MAX) begin
                        r_q      <= '1;
                        r_err_to <= 1'b1;
                        r_ack    <= w_req_s;
                        r_state  <= ST_IDLE;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign port_ack      = r_ack;
    assign port_q        = r_q;
    assign mem_cmd_valid = r_valid;
    assign mem_addr      = r_addr;
    assign mem_we        = r_we;
    assign mem_be        = r_be;
    assign mem_wdata     = r_wdata;
    assign busy          = (r_state != ST_IDLE);
    assign err_overrun   = r_err_ovr;
    assign err_timeout   = r_err_to;

endmodule
